// File: rtl/comm_pkg.sv
// Shared definitions for the remote command link: frame sequencing states,
// UART framing constants and the byte-select helper used by the transmitter.
package comm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BYTE_CMD = 2'd1,
        BYTE_HI  = 2'd2,
        BYTE_LO  = 2'd3
    } frame_state_t;

    localparam int BAUD_DIV_DEFAULT   = 2604;
    localparam int UART_BITS_PER_BYTE = 10;
    localparam int FRAME_BYTES        = 3;

    // Pick byte idx (0 = first on the wire) out of a {cmd, data} frame word
    function automatic logic [7:0] frame_byte(input logic [23:0] word,
                                              input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[23:16];
            2'd1:    b = word[15:8];
            2'd2:    b = word[7:0];
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 UART serialiser. A trmt pulse loads start/data/stop into a
// 10-bit shift register; each bit is held for BAUD_DIV clocks. tx_done is
// combinational so a caller can reload on the same edge and keep bytes
// back-to-back with no idle bit.
module uart_tx_byte
    import comm_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [3:0]  BIT_LAST  = 4'(UART_BITS_PER_BYTE - 1);

    logic [9:0]  shift_reg;
    logic [11:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic        active;
    logic        baud_tick;

    assign baud_tick = active && (baud_cnt == BAUD_LAST);
    assign tx_done   = baud_tick && (bit_cnt == BIT_LAST);

    // LSB of the shift register is the line; all-ones when idle keeps TX high
    assign TX = shift_reg[0];

    // Load on trmt, otherwise count baud periods and shift one bit per period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            active    <= 1'b0;
        end else if (trmt) begin
            shift_reg <= {1'b1, tx_data, 1'b0};
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            active    <= 1'b1;
        end else if (active) begin
            if (baud_tick) begin
                baud_cnt  <= '0;
                shift_reg <= {1'b1, shift_reg[9:1]};
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt <= '0;
                    active  <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 12'd1;
            end
        end
    end

endmodule

// File: rtl/cmd_frame_tx.sv
// Remote-side command frame transmitter: sends cmd, data[15:8], data[7:0] as
// three back-to-back 8N1 bytes. The serialiser is started combinationally on
// the accepting edge so the start bit appears the cycle after acceptance.
module cmd_frame_tx
    import comm_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic        send_cmd,
    output logic        TX,
    output logic        busy,
    output logic        cmd_sent
);

    localparam int IDX_W = $clog2(FRAME_BYTES);

    frame_state_t     state;
    logic [23:0]      hold;
    logic [23:0]      frame_word;
    logic             tx_done;
    logic             trmt;
    logic             accept;
    logic [IDX_W-1:0] byte_idx;
    logic [7:0]       tx_byte;

    uart_tx_byte #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte (
        .clk    (clk),
        .rst    (rst),
        .trmt   (trmt),
        .tx_data(tx_byte),
        .TX     (TX),
        .tx_done(tx_done)
    );

    // Accept from idle, or on the very edge the last stop bit finishes so
    // consecutive frames chain without a gap; pick which byte to launch
    always_comb begin
        accept     = send_cmd && ((state == IDLE) || ((state == BYTE_LO) && tx_done));
        frame_word = accept ? {cmd, data} : hold;
        trmt       = 1'b0;
        byte_idx   = '0;
        if (accept) begin
            trmt     = 1'b1;
            byte_idx = 2'd0;
        end else if (tx_done) begin
            case (state)
                BYTE_CMD: begin
                    trmt     = 1'b1;
                    byte_idx = 2'd1;
                end
                BYTE_HI: begin
                    trmt     = 1'b1;
                    byte_idx = 2'd2;
                end
                default: ;
            endcase
        end
        tx_byte = frame_byte(frame_word, byte_idx);
    end

    // Byte-sequencing FSM with the holding register and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold     <= '0;
            busy     <= 1'b0;
            cmd_sent <= 1'b0;
        end else if (accept) begin
            state    <= BYTE_CMD;
            hold     <= {cmd, data};
            busy     <= 1'b1;
            cmd_sent <= 1'b0;
        end else begin
            case (state)
                BYTE_CMD: if (tx_done) state <= BYTE_HI;
                BYTE_HI:  if (tx_done) state <= BYTE_LO;
                BYTE_LO: begin
                    if (tx_done) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        cmd_sent <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Bench for cmd_frame_tx with BAUD_DIV=4 (120-cycle frames). A line monitor
// decodes TX mid-bit and compares each byte against a queue of expected
// bytes filled when a frame is requested.
module tb_cmd_frame_tx;

    localparam int BD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        send_cmd;
    logic        TX;
    logic        busy;
    logic        cmd_sent;

    int total = 0;
    int bad   = 0;
    int fc    = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_log[$];

    logic [7:0] mb;
    logic       mok;
    int         bit_no;

    cmd_frame_tx #(
        .BAUD_DIV(BD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cmd),
        .data    (data),
        .send_cmd(send_cmd),
        .TX      (TX),
        .busy    (busy),
        .cmd_sent(cmd_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        fc++;
    endtask

    // Request a frame; nexp of its bytes are expected to complete on the line
    task automatic send(input logic [7:0] c, input logic [15:0] d, input int nexp);
        logic [7:0] bytes [3];
        bytes[0] = c;
        bytes[1] = d[15:8];
        bytes[2] = d[7:0];
        @(negedge clk);
        cmd      = c;
        data     = d;
        send_cmd = 1'b1;
        for (int i = 0; i < nexp; i++) exp_q.push_back(bytes[i]);
        @(negedge clk);
        fc = 1;
        chk("acc_busy", 32'(busy), 32'd1);
        chk("acc_sent", 32'(cmd_sent), 32'd0);
        chk("acc_start", 32'(TX), 32'd0);
        send_cmd = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        while (!cmd_sent && fc < 300) tick();
        chk(tag, 32'(fc), 32'd121);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_tx", 32'(TX), 32'd1);
    endtask

    // Line monitor: start bit seen at a negedge, sample each bit at its middle
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && TX === 1'b0) begin
                mok = 1'b1;
                mb  = '0;
                for (int i = 1; i < 10 * BD; i++) begin
                    @(negedge clk);
                    if (rst) mok = 1'b0;
                    if (mok && (i % BD) == BD / 2) begin
                        bit_no = i / BD;
                        if (bit_no == 0)      chk("start_bit", 32'(TX), 32'd0);
                        else if (bit_no == 9) chk("stop_bit", 32'(TX), 32'd1);
                        else                  mb[bit_no-1] = TX;
                    end
                end
                if (mok) begin
                    rx_log.push_back(mb);
                    if (exp_q.size() == 0) chk("extra_byte", 32'(mb), 32'h100);
                    else                   chk("rx_byte", 32'(mb), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int n0;
        int busy_hi;
        rst      = 1'b1;
        send_cmd = 1'b0;
        cmd      = '0;
        data     = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'({TX, busy, cmd_sent}), 32'b100);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle", 32'({TX, busy, cmd_sent}), 32'b100);
        end

        // Basic frame
        send(8'hA1, 16'hB2C3, 3);
        wait_done("lat_a1");
        repeat (5) tick();
        chk("sent_held", 32'(cmd_sent), 32'd1);
        chk("sb_empty_a1", 32'(exp_q.size()), 32'd0);

        // Frame reassembled as a receiver would see it
        send(8'h23, 16'h0897, 3);
        wait_done("lat_23");
        repeat (3) tick();
        n0 = rx_log.size();
        chk("loopback", 32'({rx_log[n0-3], rx_log[n0-2], rx_log[n0-1]}), 32'h230897);

        // send_cmd while busy is ignored
        n0 = rx_log.size();
        send(8'h11, 16'h2233, 3);
        while (fc < 40) tick();
        cmd      = 8'hFF;
        data     = 16'hFFFF;
        send_cmd = 1'b1;
        tick();
        send_cmd = 1'b0;
        wait_done("lat_busy_ign");
        busy_hi = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (busy) busy_hi++;
        end
        chk("no_queued", 32'(busy_hi), 32'd0);
        chk("one_frame", 32'(rx_log.size() - n0), 32'd3);

        // Reset mid-frame: only the command byte completes
        send(8'h3C, 16'h4A5E, 1);
        while (fc < 55) tick();
        chk("pre_rst_tx", 32'(TX), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_async", 32'({TX, busy, cmd_sent}), 32'b100);
        repeat (3) tick();
        rst = 1'b0;
        busy_hi = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (busy || !TX) busy_hi++;
        end
        chk("no_resume", 32'(busy_hi), 32'd0);
        chk("rst_sb_empty", 32'(exp_q.size()), 32'd0);
        send(8'h5A, 16'h0001, 3);
        wait_done("lat_5a");

        // Back-to-back: request on the edge busy falls
        repeat (10) tick();
        send(8'h66, 16'h1234, 3);
        while (fc < 120) tick();
        chk("b2b_busy_pre", 32'(busy), 32'd1);
        cmd      = 8'h7E;
        data     = 16'hC001;
        send_cmd = 1'b1;
        exp_q.push_back(8'h7E);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'h01);
        tick();
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_sent", 32'(cmd_sent), 32'd0);
        chk("b2b_start", 32'(TX), 32'd0);
        send_cmd = 1'b0;
        fc = 1;
        wait_done("lat_7e");

        repeat (50) tick();
        chk("sb_empty_end", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmd_frame_tx.md
Name: cmd_frame_tx

Overview:
- Remote-side command frame transmitter; the counterpart of the quad's command receiver in UART_comm.
- Accepts an 8-bit command and 16-bit data word with a one-cycle send strobe.
- Serialises them as three back-to-back 8N1 UART bytes (cmd, data[15:8], data[7:0]) on TX.
- Flags completion to the remote control logic via cmd_sent.

Parameters:
- BAUD_DIV, 2604: clk cycles per UART bit (50 MHz / 19200 baud); legal range 2..4095.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- cmd  in  8  command byte, sampled only on accepted send_cmd
- data  in  16  data word, sampled only on accepted send_cmd
- send_cmd  in  1  one-cycle request to transmit a frame
- TX  out  1  UART serial output, idle high
- busy  out  1  high while a frame is in progress
- cmd_sent  out  1  high once the frame's final stop bit completes; held until the next accepted send_cmd

Behaviour:
- Clocking/reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: TX=1, busy=0, cmd_sent=0; FSM in IDLE; counters cleared; latched cmd/data cleared.
- Reset mid-frame: TX returns high immediately (asynchronous). The frame is abandoned and is not resumed after reset deasserts.
- Accept: send_cmd sampled high at edge N while busy=0.
  - Latch {cmd,data} into a 24-bit holding register.
  - busy=1 and cmd_sent=0 from N+1.
  - Start bit of byte 0 drives TX low from N+1.
- Busy handling: send_cmd while busy=1 is ignored; latched values are unaffected and no queueing occurs.
- Top FSM: IDLE -> BYTE_CMD -> BYTE_HI -> BYTE_LO -> IDLE.
  - Each byte state asserts trmt to the byte serialiser for one cycle on entry.
  - Each byte state advances on the serialiser's tx_done.
- Byte format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit holds for exactly BAUD_DIV cycles.
- No gap between bytes: the next start bit begins the cycle after the previous stop bit ends.
- Frame length: exactly 30*BAUD_DIV cycles, from N+1 to N+30*BAUD_DIV inclusive.
- Completion: at edge N+30*BAUD_DIV, busy=0 and cmd_sent=1; TX stays 1.
- Back-to-back frames: a send_cmd that arrives on the same edge busy falls is accepted. The next frame starts immediately and cmd_sent clears again.
- Baud counter: 12-bit; counts up to BAUD_DIV-1 then wraps to 0 and shifts. Count is held at 0 when not transmitting.
- Bit counter: 4-bit, 0..9 per byte; tx_done pulses one cycle when count 9 expires.
- Input stability: cmd/data changes after acceptance have no effect on the current frame.

Decomposition:
- Shared package comm_pkg:
  - frame_state_t enum (IDLE, BYTE_CMD, BYTE_HI, BYTE_LO)
  - BAUD_DIV_DEFAULT = 2604
  - UART_BITS_PER_BYTE = 10
  - FRAME_BYTES = 3
- Sub-module uart_tx_byte(clk, rst, trmt, tx_data[7:0], TX, tx_done):
  - 10-bit shift register, baud counter, bit counter.
  - Reusable by the quad-side response path.
- cmd_frame_tx keeps only the byte-sequencing FSM, holding register, busy and cmd_sent.

Test Plan (BAUD_DIV=4 for simulation; frame = 120 cycles):
- Reset, then idle 50 cycles -> TX=1, busy=0, cmd_sent=0 throughout.
- cmd=8'hA1, data=16'hB2C3, pulse send_cmd -> TX sampled mid-bit yields bytes A1, B2, C3 (LSB first, framed start/stop). cmd_sent rises exactly 120 cycles after acceptance.
- Loopback into UART_comm with cmd=8'h23, data=16'h0897 -> UART_comm cmd_rdy rises with cmd=23, data=0897. Timeout at 1,000,000 cycles is fatal.
- Pulse send_cmd with cmd=8'hFF at cycle 40 of a frame for 8'h11/16'h2233 -> captured bytes are still 11, 22, 33. Exactly one frame is sent; busy falls at cycle 120.
- Assert rst at cycle 55 of a frame -> TX=1 in the same cycle, busy=0, cmd_sent=0. A new send_cmd (8'h5A/16'h0001) yields a clean frame 5A, 00, 01.
- send_cmd on the edge busy falls (cmd=8'h7E, data=16'hC001) -> second frame starts the next cycle with no idle bit. cmd_sent is high for at most one cycle between frames.
